dram_x16_bridge: RTL

- Sits directly downstream of the DRAM read/write buffer.
- Consumes its single-outstanding 32-bit word requests: ext_dram_mem_addr, read/write enable pulses, byte enable and write data.
- Converts each request into two 16-bit Avalon-MM pipelined transactions to the board SDRAM controller.
- Reassembles read data and returns a one-cycle ack with 32-bit read data to the buffer.

---
 rtl/dram_x16_bridge.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dram_x16_bridge.sv
// Splits single-outstanding 32-bit word requests into two 16-bit Avalon-MM pipelined
// transactions and reassembles read beats into a one-cycle ack with 32-bit data.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 24
`endif

module dram_x16_bridge #(
  parameter int unsigned ADDR_BITS     = `MEM_ADDR_BITS,
  parameter int unsigned AVM_ADDR_BITS = `MEM_ADDR_BITS + 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_BITS-1:0]     mem_addr,
  input  logic                     mem_read_en,
  input  logic                     mem_write_en,
  input  logic [3:0]               mem_byte_enable,
  input  logic [31:0]              mem_write_data,
  output logic                     mem_ack,
  output logic [31:0]              mem_read_data,
  output logic [AVM_ADDR_BITS-1:0] avm_address,
  output logic                     avm_read,
  output logic                     avm_write,
  output logic [1:0]               avm_byteenable,
  output logic [15:0]              avm_writedata,
  input  logic                     avm_waitrequest,
  input  logic [15:0]              avm_readdata,
  input  logic                     avm_readdatavalid,
  output logic                     busy,
  output logic                     protocol_error
);

  typedef enum logic [2:0] {StIdle, StLo, StHi, StRdWait, StDone} state_e;

  state_e               state;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 op_write_q;
  logic [1:0]           be_hi_q;
  logic [15:0]          wdata_hi_q;
  logic [1:0]           beat_cnt;
  logic [31:0]          rdata_q;

  logic        req;
  logic        accepted;
  logic        beat_ok;
  logic [1:0]  beats_now;
  logic [31:0] rdata_merged;

  always_comb begin
    req       = mem_read_en | mem_write_en;
    accepted  = (avm_read | avm_write) & ~avm_waitrequest;
    // Beats may land while HI is still stalled, so count in any non-idle read state.
    beat_ok   = avm_readdatavalid && (state != StIdle) && !op_write_q && (beat_cnt < 2'd2);
    beats_now = beat_cnt + {1'b0, beat_ok};
    rdata_merged = rdata_q;
    if (beat_ok) begin
      if (beat_cnt == 2'd0) rdata_merged[15:0]  = avm_readdata;
      else                  rdata_merged[31:16] = avm_readdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= StIdle;
      addr_q         <= '0;
      op_write_q     <= 1'b0;
      be_hi_q        <= '0;
      wdata_hi_q     <= '0;
      beat_cnt       <= '0;
      rdata_q        <= '0;
      mem_ack        <= 1'b0;
      mem_read_data  <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_byteenable <= '0;
      avm_writedata  <= '0;
      busy           <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      mem_ack <= 1'b0;
      if (beat_ok) begin
        beat_cnt <= beats_now;
        rdata_q  <= rdata_merged;
      end
      if ((req && state != StIdle) || (mem_read_en && mem_write_en) ||
          (avm_readdatavalid && !beat_ok)) begin
        protocol_error <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (req) begin
            addr_q     <= mem_addr;
            op_write_q <= mem_write_en;
            be_hi_q    <= mem_byte_enable[3:2];
            wdata_hi_q <= mem_write_data[31:16];
            busy       <= 1'b1;
            if (!mem_write_en || mem_byte_enable[1:0] != 2'b00) begin
              state          <= StLo;
              avm_read       <= ~mem_write_en;
              avm_write      <= mem_write_en;
              avm_address    <= {mem_addr, 1'b0};
              avm_byteenable <= mem_write_en ? mem_byte_enable[1:0] : 2'b11;
              avm_writedata  <= mem_write_en ? mem_write_data[15:0] : 16'h0;
            end else if (mem_byte_enable[3:2] != 2'b00) begin
              state          <= StHi;
              avm_write      <= 1'b1;
              avm_address    <= {mem_addr, 1'b1};
              avm_byteenable <= mem_byte_enable[3:2];
              avm_writedata  <= mem_write_data[31:16];
            end else begin
              state   <= StDone;
              mem_ack <= 1'b1;
            end
          end
        end
        StLo: begin
          if (accepted) begin
            if (!op_write_q || be_hi_q != 2'b00) begin
              state          <= StHi;
              avm_address    <= {addr_q, 1'b1};
              avm_byteenable <= op_write_q ? be_hi_q : 2'b11;
              avm_writedata  <= op_write_q ? wdata_hi_q : 16'h0;
            end else begin
              state          <= StDone;
              mem_ack        <= 1'b1;
              avm_write      <= 1'b0;
              avm_address    <= '0;
              avm_byteenable <= '0;
              avm_writedata  <= '0;
            end
          end
        end
        StHi: begin
          if (accepted) begin
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
            if (op_write_q || beats_now == 2'd2) begin
              state   <= StDone;
              mem_ack <= 1'b1;
              if (!op_write_q) mem_read_data <= rdata_merged;
            end else begin
              state <= StRdWait;
            end
          end
        end
        StRdWait: begin
          if (beats_now == 2'd2) begin
            state         <= StDone;
            mem_ack       <= 1'b1;
            mem_read_data <= rdata_merged;
          end
        end
        StDone: begin
          state    <= StIdle;
          busy     <= 1'b0;
          beat_cnt <= '0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
